// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between three result
//   producers:
//     - port A: the ALU/JAL path
//     - port L: the load unit
//     - port M: the multi-cycle mul/div unit
//   The normal fixed priority is L > M > A. Each port has an aging counter.
//   When a port has waited AGE_LIMIT cycles, it is promoted ahead of the
//   fixed order, so that no port starves.
//   On a mispredict flush, speculative A/M results are swallowed. A load
//   that reports a memory fault is dropped, and an error pulse is raised in
//   place of the write.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   a_valid/a_rd/a_data      port A request (held stable until a_ready)
//   a_ready                  port A accepted this cycle (combinational)
//   l_valid/l_rd/l_data      load port request
//   l_ready                  load port accepted this cycle (combinational)
//   m_valid/m_rd/m_data      mul/div port request
//   m_ready                  mul/div port accepted this cycle (combinational)
//   mispredict_flush         squash any A/M result presented this cycle
//   memory_error             marks the current L result as faulted
//   rf_we/rf_waddr/rf_wdata  registered register-file write
//   err_valid/err_rd         registered one-cycle pulse for a dropped load
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int AGE_LIMIT = 4,
    parameter int AGE_W     = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    input  logic [4:0]        a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,

    input  logic              l_valid,
    input  logic [4:0]        l_rd,
    input  logic [DATA_W-1:0] l_data,
    output logic              l_ready,

    input  logic              m_valid,
    input  logic [4:0]        m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,

    input  logic              mispredict_flush,
    input  logic              memory_error,

    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err_valid,
    output logic [4:0]        err_rd
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    // Aging counters, one per port
    logic [AGE_W-1:0] a_age;
    logic [AGE_W-1:0] l_age;
    logic [AGE_W-1:0] m_age;

    // A port counts as aged once it has waited the full limit
    logic a_aged;
    logic l_aged;
    logic m_aged;

    // Grants that lead to a write (or a fault report), and flush drops
    logic grant_a;
    logic grant_l;
    logic grant_m;
    logic drop_a;
    logic drop_m;

    // Selected result heading for the output register
    logic              sel_valid;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              load_fault;
    logic              do_write;

    assign a_aged = (a_age >= AGE_MAX);
    assign l_aged = (l_age >= AGE_MAX);
    assign m_aged = (m_age >= AGE_MAX);

    // Next value of one aging counter.
    // The counter counts up, saturating, while the port waits with valid high.
    // It clears once the port is accepted or its valid drops.
    function automatic logic [AGE_W-1:0] age_next(
        input logic             valid,
        input logic             ready,
        input logic [AGE_W-1:0] age
    );
        logic [AGE_W-1:0] result;
        result = '0;
        if (valid && !ready) begin
            if (age >= AGE_MAX) begin
                result = AGE_MAX;
            end else begin
                result = age + AGE_W'(1);
            end
        end
        return result;
    endfunction

    // Grant selection.
    // During a flush, A and M are handed ready purely so that they can be
    // discarded. L then arbitrates on its own.
    // Otherwise, an aged port beats the fixed order. Ties between aged ports
    // fall back to L > M > A.
    // Nothing is granted while reset is held, so no handshake can complete
    // in a reset cycle.
    always_comb begin
        grant_a = 1'b0;
        grant_l = 1'b0;
        grant_m = 1'b0;
        drop_a  = 1'b0;
        drop_m  = 1'b0;
        if (!rst) begin
            if (mispredict_flush) begin
                grant_l = l_valid;
                drop_a  = a_valid;
                drop_m  = m_valid;
            end else if (l_valid && l_aged) begin
                grant_l = 1'b1;
            end else if (m_valid && m_aged) begin
                grant_m = 1'b1;
            end else if (a_valid && a_aged) begin
                grant_a = 1'b1;
            end else if (l_valid) begin
                grant_l = 1'b1;
            end else if (m_valid) begin
                grant_m = 1'b1;
            end else if (a_valid) begin
                grant_a = 1'b1;
            end
        end
    end

    assign a_ready = grant_a | drop_a;
    assign l_ready = grant_l;
    assign m_ready = grant_m | drop_m;

    // Mux the winning port's destination and data toward the output register.
    // A faulted load still wins the cycle, which keeps the other ports out.
    // However, it is diverted to the error pulse instead of the register file.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (grant_l) begin
            sel_valid = 1'b1;
            sel_rd    = l_rd;
            sel_data  = l_data;
        end else if (grant_m) begin
            sel_valid = 1'b1;
            sel_rd    = m_rd;
            sel_data  = m_data;
        end else if (grant_a) begin
            sel_valid = 1'b1;
            sel_rd    = a_rd;
            sel_data  = a_data;
        end
    end

    assign load_fault = grant_l & memory_error;

    // Writes to x0 are accepted upstream but never reach the register file
    assign do_write = sel_valid & ~load_fault & (sel_rd != 5'd0);

    // Aging counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_age <= '0;
            l_age <= '0;
            m_age <= '0;
        end else begin
            a_age <= age_next(a_valid, a_ready, a_age);
            l_age <= age_next(l_valid, l_ready, l_age);
            m_age <= age_next(m_valid, m_ready, m_age);
        end
    end

    // Output register.
    // The address and data only move when a real write is issued, so they
    // keep their last value in idle cycles.
    // Reset clears everything, which cancels a write that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            err_valid <= 1'b0;
            err_rd    <= '0;
        end else begin
            rf_we     <= do_write;
            err_valid <= load_fault;
            if (do_write) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
            if (load_fault) begin
                err_rd <= l_rd;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Randomized, scoreboarded bench for wb_port_arbiter.
//
// Stimulus side:
//   - Each port is modelled as a producer. A producer holds its request until
//     the reference model says that it was taken.
//   - Every cycle, the reference model decides from the arbitration rules
//     which ports are taken. The bench checks the ready outputs against that
//     decision.
//   - The bench then queues the register-file / error response expected
//     after the next edge.
//
// Monitor side:
//   - A separate process pops one entry after each rising edge and compares
//     it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DATA_W    = 32;
    localparam int AGE_LIMIT = 4;
    localparam int AGE_W     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid;
    logic [4:0]        a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              l_valid;
    logic [4:0]        l_rd;
    logic [DATA_W-1:0] l_data;
    logic              l_ready;
    logic              m_valid;
    logic [4:0]        m_rd;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              mispredict_flush;
    logic              memory_error;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              err_valid;
    logic [4:0]        err_rd;

    // Expected response for one cycle.
    // is_reset asks the monitor to also check the cleared address/data.
    typedef struct packed {
        logic              we;
        logic [4:0]        waddr;
        logic [DATA_W-1:0] wdata;
        logic              err;
        logic [4:0]        err_rd;
        logic              is_reset;
    } expect_t;

    expect_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Producer state, indexed in priority order: 0 = L, 1 = M, 2 = A
    logic              pend[3];
    logic [4:0]        prd[3];
    logic [DATA_W-1:0] pdat[3];
    int                age[3];

    wb_port_arbiter #(
        .DATA_W(DATA_W),
        .AGE_LIMIT(AGE_LIMIT),
        .AGE_W(AGE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_valid(a_valid),
        .a_rd(a_rd),
        .a_data(a_data),
        .a_ready(a_ready),
        .l_valid(l_valid),
        .l_rd(l_rd),
        .l_data(l_data),
        .l_ready(l_ready),
        .m_valid(m_valid),
        .m_rd(m_rd),
        .m_data(m_data),
        .m_ready(m_ready),
        .mispredict_flush(mispredict_flush),
        .memory_error(memory_error),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .err_valid(err_valid),
        .err_rd(err_rd)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Load a new request into one producer
    task automatic setReq(input int p, input logic [4:0] rd, input logic [DATA_W-1:0] data);
        pend[p] = 1'b1;
        prd[p]  = rd;
        pdat[p] = data;
    endtask

    // Drive one clock cycle of stimulus from the producer state.
    // Then work out from the arbitration rules who gets taken, check the
    // readies, and queue the response expected after the edge.
    task automatic applyStimulus(input logic do_rst, input logic flush, input logic memerr);
        logic    acc[3];
        int      win;
        expect_t e;
        @(negedge clk);
        rst              = do_rst;
        mispredict_flush = flush;
        memory_error     = memerr;
        l_valid = pend[0]; l_rd = prd[0]; l_data = pdat[0];
        m_valid = pend[1]; m_rd = prd[1]; m_data = pdat[1];
        a_valid = pend[2]; a_rd = prd[2]; a_data = pdat[2];
        #1;
        win = -1;
        for (int i = 0; i < 3; i++) acc[i] = 1'b0;
        if (!do_rst) begin
            if (flush) begin
                if (pend[0]) win = 0;
                acc[1] = pend[1];
                acc[2] = pend[2];
            end else begin
                for (int i = 0; i < 3; i++)
                    if (win < 0 && pend[i] && age[i] >= AGE_LIMIT) win = i;
                for (int i = 0; i < 3; i++)
                    if (win < 0 && pend[i]) win = i;
            end
            if (win >= 0) acc[win] = 1'b1;
        end
        checkOutput("l_ready", 32'(l_ready), 32'(acc[0]));
        checkOutput("m_ready", 32'(m_ready), 32'(acc[1]));
        checkOutput("a_ready", 32'(a_ready), 32'(acc[2]));

        e = '0;
        if (do_rst) begin
            e.is_reset = 1'b1;
        end else if (win == 0 && memerr) begin
            e.err    = 1'b1;
            e.err_rd = prd[0];
        end else if (win >= 0 && prd[win] != 5'd0) begin
            e.we    = 1'b1;
            e.waddr = prd[win];
            e.wdata = pdat[win];
        end
        exp_q.push_back(e);

        for (int i = 0; i < 3; i++) begin
            if (do_rst || !pend[i] || acc[i]) age[i] = 0;
            else if (age[i] < AGE_LIMIT) age[i] = age[i] + 1;
            if (acc[i]) pend[i] = 1'b0;
        end
    endtask

    // Monitor: after every rising edge, compare the DUT outputs with the
    // next queued expectation
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("rf_we", 32'(rf_we), 32'(e.we));
            checkOutput("err_valid", 32'(err_valid), 32'(e.err));
            if (e.we || e.is_reset) begin
                checkOutput("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                checkOutput("rf_wdata", rf_wdata, e.wdata);
            end
            if (e.err || e.is_reset)
                checkOutput("err_rd", 32'(err_rd), 32'(e.err_rd));
        end
    end

    initial begin
        rst = 1'b1;
        mispredict_flush = 1'b0;
        memory_error = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        l_valid = 1'b0; l_rd = '0; l_data = '0;
        m_valid = 1'b0; m_rd = '0; m_data = '0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0;
            prd[i]  = '0;
            pdat[i] = '0;
            age[i]  = 0;
        end

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] single A request");
        setReq(2, 5'd5, 32'h1234);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] A, L, M together");
        setReq(0, 5'd10, 32'hAAAA_0001);
        setReq(1, 5'd11, 32'hBBBB_0002);
        setReq(2, 5'd12, 32'hCCCC_0003);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] starvation of A behind continuous L");
        setReq(2, 5'd3, 32'h0000_0333);
        for (int i = 0; i < 7; i++) begin
            if (!pend[0]) setReq(0, 5'(i + 16), 32'h5000_0000 + 32'(i));
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        while (pend[0]) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] mispredict flush");
        setReq(2, 5'd7, 32'h77);
        setReq(1, 5'd9, 32'h99);
        setReq(0, 5'd2, 32'hAA);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] faulted load");
        setReq(0, 5'd4, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] write to x0, then reset over a registered write");
        setReq(2, 5'd0, 32'h0BAD);
        applyStimulus(1'b0, 1'b0, 1'b0);
        setReq(2, 5'd6, 32'h6666);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 3; p++)
                if (!pend[p] && $urandom_range(1, 0) == 1)
                    setReq(p, 5'($urandom_range(31, 0)), $urandom);
            applyStimulus($urandom_range(49, 0) == 0,
                          $urandom_range(7, 0) == 0,
                          $urandom_range(3, 0) == 0);
        end

        @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between three result producers: ALU/JAL path (port A), load unit (port L) and multi-cycle mul/div unit (port M).
- Sits between the execute/memory stage outputs and the register file, downstream of the write-back mux.
- Fixed priority L > M > A, with per-port aging counters to prevent starvation.
- Discards speculative results on mispredict flush and suppresses faulted loads.

Parameters:
- DATA_W, 32, register data width.
- AGE_LIMIT, 4, consecutive wait cycles after which a waiting port is promoted to top priority.
- AGE_W, 3, width of each aging counter; must satisfy 2^AGE_W > AGE_LIMIT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  port A result valid.
- a_rd  input  5  port A destination register.
- a_data  input  DATA_W  port A result.
- a_ready  output  1  port A accepted this cycle (combinational).
- l_valid, l_rd, l_data, l_ready  same widths/meaning, load port.
- m_valid, m_rd, m_data, m_ready  same widths/meaning, mul/div port.
- mispredict_flush  input  1  squash speculative A/M results this cycle.
- memory_error  input  1  qualifies current port-L result as faulted.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  write address (registered).
- rf_wdata  output  DATA_W  write data (registered).
- err_valid  output  1  one-cycle pulse: faulted load was dropped (registered).
- err_rd  output  5  destination register of the dropped load (registered).

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, err_valid=0, err_rd=0, all aging counters=0. While rst=1 all *_ready=0.
- Handshake:
  - A transfer occurs when x_valid && x_ready.
  - Producer holds valid, rd and data stable until accepted.
  - At most one port receives ready per cycle, except during a flush (see below).
- Grant selection (combinational, among valid ports):
  - An aged port (counter >= AGE_LIMIT) wins first. If several ports are aged, use priority L > M > A.
  - Otherwise priority is L > M > A.
- Aging:
  - A port's counter increments, saturating at AGE_LIMIT, in each cycle it is valid but not granted.
  - The counter clears when the port is granted or when its valid is low.
- Latency: one cycle. The granted result appears on rf_we/rf_waddr/rf_wdata on the next edge.
  - rf_we=0 in cycles with no transfer.
  - rf_waddr/rf_wdata hold their last value when rf_we=0.
- x0 writes: accepted normally, but rf_we=0 on output.
- mispredict_flush=1:
  - a_ready=1 if a_valid; m_ready=1 if m_valid. Both are consumed and dropped, never written.
  - Their aging counters clear.
  - Port L still arbitrates alone and writes normally if valid.
- memory_error=1 with an L transfer:
  - L is consumed; next cycle rf_we=0, err_valid=1, err_rd=l_rd.
  - No other port is granted in that cycle.
  - memory_error is ignored when there is no L transfer.
- Reset mid-operation: an in-flight registered write is cancelled (rf_we=0 next cycle). No handshake completes in a reset cycle.
- No internal buffering beyond the output register. Throughput is one write per cycle.

Test Plan:
- Reset then single A request (rd=5, data=0x1234) -> a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
- A, L, M valid together, held -> L granted cycle 0, M cycle 1, A cycle 2; writes appear in cycles 1, 2, 3 in that order.
- L valid continuously, A held valid (rd=3) -> A's counter reaches 4; A granted on the 5th cycle; rf_waddr=3 the next cycle.
- mispredict_flush with A (rd=7) and M (rd=9) and L (rd=2, data=0xAA) valid -> all three ready; next cycle only rf_waddr=2, rf_wdata=0xAA, rf_we=1.
- L transfer (rd=4) with memory_error=1 -> next cycle rf_we=0, err_valid=1, err_rd=4; err_valid low the following cycle.
- A request with rd=0 -> a_ready=1, rf_we stays 0. Assert rst while a write is registered -> rf_we=0 and all counters 0 after the edge.
